// File: rtl/data_mem_pkg.sv
// Shared definitions for the MEM-stage data memory port.
// Holds the MEM_READ/MEM_WRITE access codes, the port FSM state type,
// the FAULT_CAUSE encoding and the access-decode helpers.
package data_mem_pkg;

   // Load codes (MEM_READ)
   localparam logic [2:0] LD_NONE = 3'b000;
   localparam logic [2:0] LD_LB   = 3'b001;
   localparam logic [2:0] LD_LH   = 3'b010;
   localparam logic [2:0] LD_LW   = 3'b011;
   localparam logic [2:0] LD_LBU  = 3'b100;
   localparam logic [2:0] LD_LHU  = 3'b101;

   // Store codes (MEM_WRITE)
   localparam logic [2:0] ST_NONE = 3'b000;
   localparam logic [2:0] ST_SB   = 3'b001;
   localparam logic [2:0] ST_SH   = 3'b010;
   localparam logic [2:0] ST_SW   = 3'b011;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_DONE = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISALIGN = 2'b01,
      FC_ILLEGAL  = 2'b10,
      FC_TIMEOUT  = 2'b11
   } fault_e;

   // Illegal code takes priority over misalignment.
   function automatic fault_e access_fault(input logic [2:0] rd,
                                           input logic [2:0] wr,
                                           input logic [1:0] a);
      logic half;
      logic word;
      half = (rd == LD_LH) || (rd == LD_LHU) || (wr == ST_SH);
      word = (rd == LD_LW) || (wr == ST_SW);
      if (rd > LD_LHU || wr > ST_SW || (rd != LD_NONE && wr != ST_NONE))
         return FC_ILLEGAL;
      if ((half && a[0]) || (word && a != 2'b00))
         return FC_MISALIGN;
      return FC_NONE;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] wr,
                                           input logic [1:0] a);
      case (wr)
         ST_SB:   return 4'b0001 << a;
         ST_SH:   return a[1] ? 4'b1100 : 4'b0011;
         ST_SW:   return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   // Store data is replicated across lanes so the byte enables alone pick the target.
   function automatic logic [31:0] store_wdata(input logic [2:0] wr,
                                               input logic [31:0] wd);
      case (wr)
         ST_SB:   return {4{wd[7:0]}};
         ST_SH:   return {2{wd[15:0]}};
         ST_SW:   return wd;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_port_load_align.sv
// mem_load_align: combinational load extraction.
//   rdata   - word read from memory
//   addr_lo - byte offset within the word
//   rd_code - load code (LB/LH/LW/LBU/LHU)
//   ext     - selected byte/half, sign- or zero-extended; LW passes through
module mem_load_align
   import data_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  rd_code,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (rd_code)
         LD_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  ext = {24'h000000, byte_sel};
         LD_LH:   ext = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  ext = {16'h0000, half_sel};
         LD_LW:   ext = rdata;
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_port.sv
// data_mem_port: MEM-stage responder for ctrl_unit load/store codes.
//   CLK, RESET              - clock, asynchronous active-high reset
//   MEM_READ / MEM_WRITE    - encoded load / store request
//   ADDRESS, WRITE_DATA     - byte address and store data
//   READ_DATA               - extended load result, valid in DONE, held after
//   BUSYWAIT                - pipeline stall request
//   ACCESS_FAULT            - one-cycle pulse in DONE for a faulted access
//   FAULT_CAUSE             - last access fault cause, held until next access
//   MEM_REQ/WE/ADDR/BYTE_EN/WDATA - registered word-memory request
//   MEM_RDATA, MEM_ACK      - memory read data and completion strobe
module data_mem_port
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [2:0]        MEM_READ,
   input  logic [2:0]        MEM_WRITE,
   input  logic [ADDR_W-1:0] ADDRESS,
   input  logic [31:0]       WRITE_DATA,
   output logic [31:0]       READ_DATA,
   output logic              BUSYWAIT,
   output logic              ACCESS_FAULT,
   output logic [1:0]        FAULT_CAUSE,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-3:0] MEM_ADDR,
   output logic [3:0]        MEM_BYTE_EN,
   output logic [31:0]       MEM_WDATA,
   input  logic [31:0]       MEM_RDATA,
   input  logic              MEM_ACK
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   state_e            state_q, state_d;
   fault_e            fault_q, fault_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        rd_code_q, rd_code_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [31:0]       read_data_q, read_data_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_byte_en_q, mem_byte_en_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;

   logic              access;
   fault_e            fault_chk;
   logic [31:0]       load_ext;

   mem_load_align u_load_align (
      .rdata   (MEM_RDATA),
      .addr_lo (addr_lo_q),
      .rd_code (rd_code_q),
      .ext     (load_ext)
   );

   assign access    = (MEM_READ != LD_NONE) || (MEM_WRITE != ST_NONE);
   assign fault_chk = access_fault(MEM_READ, MEM_WRITE, ADDRESS[1:0]);

   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      cnt_d         = cnt_q;
      rd_code_d     = rd_code_q;
      addr_lo_d     = addr_lo_q;
      read_data_d   = read_data_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_byte_en_d = mem_byte_en_q;
      mem_wdata_d   = mem_wdata_q;
      BUSYWAIT      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Stall in the same cycle the access appears.
            BUSYWAIT = access;
            if (access) begin
               fault_d   = fault_chk;
               rd_code_d = MEM_READ;
               addr_lo_d = ADDRESS[1:0];
               cnt_d     = '0;
               if (fault_chk != FC_NONE) begin
                  state_d     = S_DONE;
                  read_data_d = '0;
               end else begin
                  state_d       = S_WAIT;
                  mem_req_d     = 1'b1;
                  mem_we_d      = (MEM_WRITE != ST_NONE);
                  mem_addr_d    = ADDRESS[ADDR_W-1:2];
                  mem_byte_en_d = store_be(MEM_WRITE, ADDRESS[1:0]);
                  mem_wdata_d   = store_wdata(MEM_WRITE, WRITE_DATA);
               end
            end
         end
         S_WAIT: begin
            BUSYWAIT = 1'b1;
            // Ack is tested first so it wins over a coincident timeout.
            if (MEM_ACK) begin
               state_d     = S_DONE;
               mem_req_d   = 1'b0;
               read_data_d = (rd_code_q != LD_NONE) ? load_ext : '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d     = S_DONE;
               mem_req_d   = 1'b0;
               fault_d     = FC_TIMEOUT;
               read_data_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q       <= S_IDLE;
         fault_q       <= FC_NONE;
         cnt_q         <= '0;
         rd_code_q     <= LD_NONE;
         addr_lo_q     <= '0;
         read_data_q   <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_byte_en_q <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         fault_q       <= fault_d;
         cnt_q         <= cnt_d;
         rd_code_q     <= rd_code_d;
         addr_lo_q     <= addr_lo_d;
         read_data_q   <= read_data_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_byte_en_q <= mem_byte_en_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign READ_DATA    = read_data_q;
   assign FAULT_CAUSE  = fault_q;
   assign ACCESS_FAULT = (state_q == S_DONE) && (fault_q != FC_NONE);
   assign MEM_REQ      = mem_req_q;
   assign MEM_WE       = mem_we_q;
   assign MEM_ADDR     = mem_addr_q;
   assign MEM_BYTE_EN  = mem_byte_en_q;
   assign MEM_WDATA    = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
module tb_data_mem_port;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TIMEOUT = 16;

   logic              CLK = 1'b0;
   logic              RESET;
   logic [2:0]        MEM_READ;
   logic [2:0]        MEM_WRITE;
   logic [ADDR_W-1:0] ADDRESS;
   logic [31:0]       WRITE_DATA;
   logic [31:0]       READ_DATA;
   logic              BUSYWAIT;
   logic              ACCESS_FAULT;
   logic [1:0]        FAULT_CAUSE;
   logic              MEM_REQ;
   logic              MEM_WE;
   logic [ADDR_W-3:0] MEM_ADDR;
   logic [3:0]        MEM_BYTE_EN;
   logic [31:0]       MEM_WDATA;
   logic [31:0]       MEM_RDATA;
   logic              MEM_ACK;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference view of the registered, held outputs.
   logic [31:0] exp_rd;
   logic [1:0]  exp_cause;

   data_mem_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .MEM_READ     (MEM_READ),
      .MEM_WRITE    (MEM_WRITE),
      .ADDRESS      (ADDRESS),
      .WRITE_DATA   (WRITE_DATA),
      .READ_DATA    (READ_DATA),
      .BUSYWAIT     (BUSYWAIT),
      .ACCESS_FAULT (ACCESS_FAULT),
      .FAULT_CAUSE  (FAULT_CAUSE),
      .MEM_REQ      (MEM_REQ),
      .MEM_WE       (MEM_WE),
      .MEM_ADDR     (MEM_ADDR),
      .MEM_BYTE_EN  (MEM_BYTE_EN),
      .MEM_WDATA    (MEM_WDATA),
      .MEM_RDATA    (MEM_RDATA),
      .MEM_ACK      (MEM_ACK)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned acc_size(input logic [2:0] rd, input logic [2:0] wr);
      if (rd == 3'd1 || rd == 3'd4 || wr == 3'd1) return 1;
      if (rd == 3'd2 || rd == 3'd5 || wr == 3'd2) return 2;
      return 4;
   endfunction

   function automatic logic [1:0] ref_fault(input logic [2:0] rd, input logic [2:0] wr,
                                            input logic [1:0] a);
      if (rd > 3'd5 || wr > 3'd3 || (rd != 0 && wr != 0)) return 2'b10;
      if (int'(a) % acc_size(rd, wr) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] rd, input logic [31:0] rdata,
                                            input logic [1:0] a);
      logic [31:0] v;
      v = rdata >> (8 * int'(a));
      case (rd)
         3'd1:    return 32'($signed(v[7:0]));
         3'd2:    return 32'($signed(v[15:0]));
         3'd4:    return 32'(v[7:0]);
         3'd5:    return 32'(v[15:0]);
         3'd3:    return rdata;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] wr, input logic [1:0] a);
      logic [3:0] m;
      m = 4'((1 << acc_size(3'd0, wr)) - 1);
      if (wr == 0) return 4'h0;
      return 4'(m << int'(a));
   endfunction

   function automatic logic [31:0] ref_wd(input logic [2:0] wr, input logic [31:0] wd);
      logic [31:0] r;
      r = 32'h0;
      if (wr != 0)
         for (int i = 0; i < 4; i++)
            r[8*i +: 8] = wd[(8*i) % (8*acc_size(3'd0, wr)) +: 8];
      return r;
   endfunction

   // One access starting at a negedge in IDLE; ack_at = WAIT cycle of the ack (0 = never).
   task automatic do_access(input logic [2:0] rd, input logic [2:0] wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rdata);
      logic [1:0] f;
      logic       got_ack;
      chk("idle_read_data", 64'(READ_DATA), 64'(exp_rd));
      chk("idle_cause", 64'(FAULT_CAUSE), 64'(exp_cause));
      chk("idle_req", 64'(MEM_REQ), 64'(0));
      MEM_READ   = rd;
      MEM_WRITE  = wr;
      ADDRESS    = addr;
      WRITE_DATA = wd;
      MEM_ACK    = 1'($urandom_range(0, 1));
      #1;
      chk("idle_busy", 64'(BUSYWAIT), 64'(rd != 0 || wr != 0));
      f = ref_fault(rd, wr, addr[1:0]);
      @(negedge CLK);
      got_ack = 1'b0;
      if (f == 2'b00) begin
         for (int k = 1; k <= int'(TIMEOUT); k++) begin
            chk("wait_busy", 64'(BUSYWAIT), 64'(1));
            chk("wait_req", 64'(MEM_REQ), 64'(1));
            chk("wait_bus", 64'({MEM_WE, MEM_BYTE_EN, MEM_ADDR}),
                64'({(wr != 0), ref_be(wr, addr[1:0]), addr[31:2]}));
            chk("wait_wdata", 64'(MEM_WDATA), 64'(ref_wd(wr, wd)));
            MEM_READ   = 3'($urandom);
            MEM_WRITE  = 3'($urandom);
            ADDRESS    = $urandom;
            WRITE_DATA = $urandom;
            MEM_ACK    = (k == ack_at);
            MEM_RDATA  = (k == ack_at) ? rdata : $urandom;
            @(negedge CLK);
            if (k == ack_at) begin
               got_ack = 1'b1;
               break;
            end
         end
         exp_rd    = got_ack ? ref_load(rd, rdata, addr[1:0]) : 32'h0;
         exp_cause = got_ack ? 2'b00 : 2'b11;
      end else begin
         exp_rd    = 32'h0;
         exp_cause = f;
      end
      // DONE: whatever codes are still driven must not stall or be accepted
      chk("done_busy", 64'(BUSYWAIT), 64'(0));
      chk("done_fault", 64'(ACCESS_FAULT), 64'(exp_cause != 0));
      chk("done_cause", 64'(FAULT_CAUSE), 64'(exp_cause));
      chk("done_read_data", 64'(READ_DATA), 64'(exp_rd));
      chk("done_req", 64'(MEM_REQ), 64'(0));
      MEM_READ  = 3'd0;
      MEM_WRITE = 3'd0;
      MEM_ACK   = 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("idle_no_fault", 64'(ACCESS_FAULT), 64'(0));
      chk("idle_no_busy", 64'(BUSYWAIT), 64'(0));
      MEM_ACK = 1'b0;
   endtask

   initial begin
      logic [2:0]  rd, wr;
      logic [31:0] a;
      int          r, ack_at;

      RESET      = 1'b1;
      MEM_READ   = 3'd0;
      MEM_WRITE  = 3'd0;
      ADDRESS    = '0;
      WRITE_DATA = '0;
      MEM_RDATA  = '0;
      MEM_ACK    = 1'b0;
      exp_rd     = 32'h0;
      exp_cause  = 2'b00;
      #3;
      chk("reset_outputs",
          64'({READ_DATA, BUSYWAIT, ACCESS_FAULT, FAULT_CAUSE, MEM_REQ, MEM_WE, MEM_BYTE_EN}), 64'(0));
      chk("reset_bus", 64'({MEM_ADDR, MEM_WDATA}), 64'(0));
      @(negedge CLK);
      RESET = 1'b0;

      // SW, ack in first WAIT cycle
      do_access(3'd0, 3'd3, 32'h100, 32'hDEADBEEF, 1, 32'h0);
      // loads from one word
      do_access(3'd1, 3'd0, 32'h103, 32'h0, 1, 32'h80FF7F01);
      chk("tp_lb", 64'(READ_DATA), 64'(32'hFFFFFF80));
      do_access(3'd4, 3'd0, 32'h103, 32'h0, 2, 32'h80FF7F01);
      chk("tp_lbu", 64'(READ_DATA), 64'(32'h00000080));
      do_access(3'd2, 3'd0, 32'h102, 32'h0, 1, 32'h80FF7F01);
      chk("tp_lh", 64'(READ_DATA), 64'(32'hFFFF80FF));
      do_access(3'd5, 3'd0, 32'h102, 32'h0, 3, 32'h80FF7F01);
      chk("tp_lhu", 64'(READ_DATA), 64'(32'h000080FF));
      // store steering
      do_access(3'd0, 3'd1, 32'h202, 32'h123456AB, 1, 32'h0);
      do_access(3'd0, 3'd2, 32'h202, 32'h123456AB, 1, 32'h0);
      // faults
      do_access(3'd3, 3'd0, 32'h102, 32'h0, 1, 32'h0);
      do_access(3'd0, 3'd4, 32'h100, 32'h0, 1, 32'h0);
      do_access(3'd3, 3'd3, 32'h100, 32'h0, 1, 32'h0);
      // timeout, then ack exactly on the last WAIT cycle
      do_access(3'd3, 3'd0, 32'h104, 32'h0, 0, 32'h0);
      do_access(3'd3, 3'd0, 32'h108, 32'h0, int'(TIMEOUT), 32'hCAFEF00D);
      chk("tp_ack_last", 64'(READ_DATA), 64'(32'hCAFEF00D));

      // asynchronous reset in the middle of WAIT
      MEM_READ = 3'd3;
      ADDRESS  = 32'h300;
      @(negedge CLK);
      MEM_READ = 3'd0;
      @(negedge CLK);
      chk("pre_reset_req", 64'(MEM_REQ), 64'(1));
      #2 RESET = 1'b1;
      #1;
      chk("async_reset", 64'({MEM_REQ, BUSYWAIT, READ_DATA, FAULT_CAUSE}), 64'(0));
      @(negedge CLK);
      RESET     = 1'b0;
      exp_rd    = 32'h0;
      exp_cause = 2'b00;
      MEM_ACK   = 1'b1;
      @(negedge CLK);
      chk("stale_ack", 64'({MEM_REQ, BUSYWAIT, ACCESS_FAULT, READ_DATA}), 64'(0));
      MEM_ACK = 1'b0;
      do_access(3'd3, 3'd0, 32'h300, 32'h0, 1, 32'h13572468);

      // randomized accesses
      for (int n = 0; n < 150; n++) begin
         r  = int'($urandom_range(0, 9));
         rd = 3'd0;
         wr = 3'd0;
         if (r < 5)       rd = 3'($urandom_range(1, 5));
         else if (r < 8)  wr = 3'($urandom_range(1, 3));
         else if (r == 8) rd = 3'($urandom_range(6, 7));
         else begin
            rd = 3'($urandom);
            wr = 3'($urandom);
         end
         if (rd == 0 && wr == 0) wr = 3'd3;
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         r = int'($urandom_range(0, 7));
         ack_at = (r == 0) ? 0 : (r == 1) ? int'(TIMEOUT) : int'($urandom_range(1, 4));
         do_access(rd, wr, a, $urandom, ack_at, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
